// File: rtl/conv1_pkg.sv
// Shared types and default geometry for the conv1 frame scheduler.
package conv1_pkg;

  localparam int unsigned DEF_IMG_W    = 28;
  localparam int unsigned DEF_IMG_H    = 28;
  localparam int unsigned DEF_K        = 3;
  localparam int unsigned DEF_LANES    = 8;
  localparam int unsigned DEF_CONV_LAT = 9;

  localparam int unsigned DEF_OUT_W = DEF_IMG_W - DEF_K + 1;
  localparam int unsigned DEF_OUT_H = DEF_IMG_H - DEF_K + 1;
  localparam int unsigned DEF_N_WIN = DEF_OUT_W * DEF_OUT_H;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Bit width able to index v items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/conv1_xy_cnt.sv
// Raster-order row/column counter with synchronous clear, enable and wrap flags.
module conv1_xy_cnt
  import conv1_pkg::*;
#(
  parameter int unsigned W  = DEF_IMG_W,
  parameter int unsigned H  = DEF_IMG_H,
  parameter int unsigned CW = clog2_min1(W),
  parameter int unsigned RW = clog2_min1(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          col_wrap,
  output logic          row_last
);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;

  assign col_wrap = (col_q == CW'(W - 1));
  assign row_last = (row_q == RW'(H - 1));
  assign row      = row_q;
  assign col      = col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr) begin
      row_q <= '0;
      col_q <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv1_sched.sv
// Frame controller for conv1: line-buffer writes, window issue phase-locked to the
// datapath lane counter, result coordinate tagging and frame completion.
module conv1_sched
  import conv1_pkg::*;
#(
  parameter int unsigned IMG_W    = DEF_IMG_W,
  parameter int unsigned IMG_H    = DEF_IMG_H,
  parameter int unsigned K        = DEF_K,
  parameter int unsigned LANES    = DEF_LANES,
  parameter int unsigned CONV_LAT = DEF_CONV_LAT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  output logic                           lb_wr_en,
  output logic [1:0]                     lb_wr_row,
  output logic [$clog2(IMG_W)-1:0]       lb_wr_col,
  output logic                           win_valid,
  output logic [$clog2(IMG_H-K+1)-1:0]   win_row,
  output logic [$clog2(IMG_W-K+1)-1:0]   win_col,
  output logic [2:0]                     lane,
  input  logic                           conv_valid,
  output logic                           out_valid,
  output logic [$clog2(IMG_H-K+1)-1:0]   out_row,
  output logic [$clog2(IMG_W-K+1)-1:0]   out_col
);

  localparam int unsigned OUT_W = IMG_W - K + 1;
  localparam int unsigned OUT_H = IMG_H - K + 1;
  localparam int unsigned PCW   = $clog2(IMG_W);
  localparam int unsigned PRW   = $clog2(IMG_H);
  localparam int unsigned OCW   = $clog2(OUT_W);
  localparam int unsigned ORW   = $clog2(OUT_H);
  localparam int unsigned FLW   = $clog2(CONV_LAT + 1);

  state_e state_q, state_d;

  logic [2:0]     lane_q;
  logic [1:0]     ring_q;
  logic [FLW-1:0] flush_q;
  logic           fin_q;
  logic           win_valid_q;
  logic [ORW-1:0] win_row_q;
  logic [OCW-1:0] win_col_q;
  logic           out_valid_q;
  logic [ORW-1:0] out_row_q;
  logic [OCW-1:0] out_col_q;

  logic [PRW-1:0] pix_row;
  logic [PCW-1:0] pix_col;
  logic           pix_col_wrap, pix_row_last, pix_last;
  logic [ORW-1:0] res_row;
  logic [OCW-1:0] res_col;
  logic           res_col_wrap, res_row_last, res_last;

  logic running, busy_s, accept, cnt_clr, issue, res_en;

  assign running  = (state_q == StRun);
  assign busy_s   = running | (state_q == StDrain);
  assign accept   = pix_valid & running;
  assign cnt_clr  = abort | (state_q == StIdle) | (state_q == StDone);
  assign pix_last = pix_row_last & pix_col_wrap;
  assign res_last = res_row_last & res_col_wrap;
  assign issue    = accept & ~abort & (pix_row >= PRW'(K - 1)) & (pix_col >= PCW'(K - 1));
  // Results landing within CONV_LAT cycles of an abort belong to the cancelled frame.
  assign res_en   = conv_valid & busy_s & ~abort & (flush_q == '0);

  conv1_xy_cnt #(
    .W (IMG_W),
    .H (IMG_H),
    .CW(PCW),
    .RW(PRW)
  ) u_pix_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (accept & ~abort),
    .row     (pix_row),
    .col     (pix_col),
    .col_wrap(pix_col_wrap),
    .row_last(pix_row_last)
  );

  conv1_xy_cnt #(
    .W (OUT_W),
    .H (OUT_H),
    .CW(OCW),
    .RW(ORW)
  ) u_res_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (res_en),
    .row     (res_row),
    .col     (res_col),
    .col_wrap(res_col_wrap),
    .row_last(res_row_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accept && pix_last) state_d = StDrain;
      StDrain: if (fin_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Free-running phase shared with the datapath; never gated by state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else begin
      lane_q <= (lane_q == 3'(LANES - 1)) ? '0 : lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_q  <= '0;
      fin_q   <= 1'b0;
      flush_q <= '0;
    end else begin
      if (cnt_clr) begin
        ring_q <= '0;
      end else if (accept && pix_col_wrap) begin
        ring_q <= (ring_q == 2'(K - 1)) ? '0 : ring_q + 1'b1;
      end
      if (cnt_clr) begin
        fin_q <= 1'b0;
      end else if (res_en && res_last) begin
        fin_q <= 1'b1;
      end
      if (abort) begin
        flush_q <= FLW'(CONV_LAT);
      end else if (flush_q != '0) begin
        flush_q <= flush_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      win_valid_q <= issue;
      if (issue) begin
        win_row_q <= ORW'(pix_row - PRW'(K - 1));
        win_col_q <= OCW'(pix_col - PCW'(K - 1));
      end
      out_valid_q <= res_en;
      if (res_en) begin
        out_row_q <= res_row;
        out_col_q <= res_col;
      end
    end
  end

  assign busy      = busy_s;
  assign done      = (state_q == StDone);
  assign pix_ready = running;
  assign lb_wr_en  = accept;
  assign lb_wr_row = ring_q;
  assign lb_wr_col = pix_col;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign lane      = lane_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule

// File: tb/tb_conv1_sched.sv
// Directed bench for conv1_sched; the bench also plays the 9-cycle conv1 datapath.
module tb_conv1_sched;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int OW    = 26;
  localparam int OH    = 26;
  localparam int NW    = OW * OH;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pix_valid = 1'b0;
  logic       conv_valid = 1'b0;
  logic       busy, done, pix_ready, lb_wr_en, win_valid, out_valid;
  logic [1:0] lb_wr_row;
  logic [4:0] lb_wr_col, win_row, win_col, out_row, out_col;
  logic [2:0] lane;

  int tests = 0;
  int fails = 0;

  conv1_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .lb_wr_en  (lb_wr_en),
    .lb_wr_row (lb_wr_row),
    .lb_wr_col (lb_wr_col),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .lane      (lane),
    .conv_valid(conv_valid),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col)
  );

  always #5 clk = ~clk;

  // Runs one frame; inputs change and outputs are sampled on the falling edge.
  task automatic drive_frame(input int duty, input int abort_at, input bit hold_start,
                             input bit rst_drain, output int n_wr, output int n_win,
                             output int n_out, output int n_done);
    logic [15:0] hist;
    logic [2:0]  lane0;
    int pix, win, outs, tail, last_out, abort_cyc, drain_wait, first_pix;
    int lane_err, win_err, out_err, wr_err, done_err, abort_err, rst_err;
    bit aborted, ended, finishing, run_exp;
    hist = '0; pix = 0; win = 0; outs = 0; tail = 0; last_out = -10; abort_cyc = -10;
    drain_wait = 0; first_pix = -1; lane_err = 0; win_err = 0; out_err = 0; wr_err = 0;
    done_err = 0; abort_err = 0; rst_err = 0; aborted = 0; ended = 0; finishing = 0;
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = hold_start;
    lane0 = lane;
    for (int cyc = 0; cyc < 6000 && !ended; cyc++) begin
      if (lane !== 3'((32'(lane0) + cyc) % 8)) lane_err++;
      if (win_valid) begin
        if (win_row !== 5'(win / OW) || win_col !== 5'(win % OW)) begin
          if (win_err == 0)
            $display("window %0d at (%0d,%0d), want (%0d,%0d)", win, win_row, win_col,
                     win / OW, win % OW);
          win_err++;
        end
        if (win == 0) first_pix = pix;
        win++;
      end
      if (out_valid) begin
        if (aborted || out_row !== 5'(outs / OW) || out_col !== 5'(outs % OW)) out_err++;
        outs++;
        last_out = cyc;
      end
      if (done) begin
        n_done++;
        finishing = 1;
        if (busy !== 1'b0 || last_out != cyc - 1 || outs != NW) done_err++;
      end
      if (aborted && cyc == abort_cyc + 1 && (busy !== 1'b0 || done !== 1'b0)) abort_err++;
      if (finishing) tail++;
      if (tail >= 20) ended = 1;
      if (rst_drain && pix == NPIX) begin
        drain_wait++;
        if (drain_wait == 6) begin
          if (busy !== 1'b1) rst_err++;
          #2;
          rst_n = 1'b0;
          #1;
          if ({busy, done, pix_ready, lb_wr_en, win_valid, out_valid} !== 6'b0) rst_err++;
          if ({lb_wr_row, lb_wr_col, win_row, win_col, out_row, out_col, lane} !== '0)
            rst_err++;
          ended = 1;
        end
      end
      if (!ended) begin
        run_exp   = !aborted && pix < NPIX;
        hist      = {hist[14:0], win_valid};
        conv_valid = hist[9];
        start     = hold_start && pix < 400 && !aborted;
        abort     = !aborted && abort_at >= 0 && pix == abort_at;
        if (abort) begin
          aborted   = 1;
          finishing = 1;
          abort_cyc = cyc;
        end
        if (!run_exp || abort) pix_valid = 1'b0;
        else if (duty == 100) pix_valid = 1'b1;
        else pix_valid = 1'($urandom_range(0, 1));
        #1;
        if (pix_ready !== run_exp || lb_wr_en !== (pix_valid & run_exp)) wr_err++;
        if (lb_wr_en) begin
          if (lb_wr_row !== 2'((pix / IMG_W) % K) || lb_wr_col !== 5'(pix % IMG_W)) wr_err++;
          pix++;
        end
        @(negedge clk);
        abort = 1'b0;
      end
    end
    start = 1'b0; abort = 1'b0; pix_valid = 1'b0; conv_valid = 1'b0;
    tests++;
    if (!ended) begin
      fails++;
      $display("FAIL frame_timeout: frame did not finish, got %0d results want %0d", outs, NW);
    end
    tests++;
    if (lane_err != 0) begin
      fails++; $display("FAIL lane_phase: %0d cycles off the +1 sequence, want 0", lane_err);
    end
    tests++;
    if (win_err != 0) begin
      fails++; $display("FAIL win_coord: %0d windows out of raster order, want 0", win_err);
    end
    tests++;
    if (out_err != 0) begin
      fails++; $display("FAIL out_coord: %0d bad out_valid tags, want 0", out_err);
    end
    tests++;
    if (wr_err != 0) begin
      fails++; $display("FAIL lb_write: %0d bad ready/write/row/col cycles, want 0", wr_err);
    end
    tests++;
    if (done_err != 0) begin
      fails++; $display("FAIL done_timing: %0d bad done cycles, want 0", done_err);
    end
    if (abort_at >= 0) begin
      tests++;
      if (abort_err != 0) begin
        fails++; $display("FAIL abort_idle: busy/done after abort, got %0d errs want 0", abort_err);
      end
    end
    if (rst_drain) begin
      tests++;
      if (rst_err != 0) begin
        fails++; $display("FAIL reset_drain: %0d outputs not at reset value, want 0", rst_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    if (duty == 100 && abort_at < 0 && !rst_drain) begin
      tests++;
      if (first_pix != 59) begin
        fails++; $display("FAIL first_window: after %0d pixels, want 59", first_pix);
      end
    end
    n_wr = pix; n_win = win; n_out = outs;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = i[0]; abort = i[1]; pix_valid = 1'b1; conv_valid = 1'b1;
      #1;
      tests++;
      if ({busy, done, pix_ready, lb_wr_en, win_valid, out_valid} !== 6'b0) begin
        fails++;
        $display("FAIL reset_ctrl: got %b want 000000",
                 {busy, done, pix_ready, lb_wr_en, win_valid, out_valid});
      end
      tests++;
      if ({lb_wr_row, lb_wr_col, win_row, win_col, out_row, out_col, lane} !== '0) begin
        fails++;
        $display("FAIL reset_coord: got %h want 0",
                 {lb_wr_row, lb_wr_col, win_row, win_col, out_row, out_col, lane});
      end
    end
    start = 1'b0; abort = 1'b0; pix_valid = 1'b0; conv_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++;
      if (lane !== 3'(i % 8)) begin
        fails++; $display("FAIL lane_count[%0d]: got %0d want %0d", i, lane, i % 8);
      end
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: busy got %b want 0", busy);
    end
  endtask

  task automatic test_full_frame();
    int n_wr, n_win, n_out, n_done;
    drive_frame(100, -1, 1'b0, 1'b0, n_wr, n_win, n_out, n_done);
    tests++;
    if (n_wr != NPIX || n_win != NW || n_out != NW || n_done != 1) begin
      fails++;
      $display("FAIL full_counts: got wr=%0d win=%0d out=%0d done=%0d want %0d/%0d/%0d/1",
               n_wr, n_win, n_out, n_done, NPIX, NW, NW);
    end
    tests++;
    if (out_row !== 5'(OH - 1) || out_col !== 5'(OW - 1)) begin
      fails++; $display("FAIL full_last_out: got (%0d,%0d) want (25,25)", out_row, out_col);
    end
  endtask

  task automatic test_gaps();
    int n_wr, n_win, n_out, n_done;
    drive_frame(50, -1, 1'b0, 1'b0, n_wr, n_win, n_out, n_done);
    tests++;
    if (n_wr != NPIX || n_win != NW || n_out != NW || n_done != 1) begin
      fails++;
      $display("FAIL gap_counts: got wr=%0d win=%0d out=%0d done=%0d want %0d/%0d/%0d/1",
               n_wr, n_win, n_out, n_done, NPIX, NW, NW);
    end
  endtask

  task automatic test_abort();
    int n_wr, n_win, n_out, n_done;
    drive_frame(100, 300, 1'b0, 1'b0, n_wr, n_win, n_out, n_done);
    tests++;
    if (n_wr != 300 || n_done != 0) begin
      fails++; $display("FAIL abort_frame: got wr=%0d done=%0d want 300/0", n_wr, n_done);
    end
    drive_frame(100, -1, 1'b0, 1'b0, n_wr, n_win, n_out, n_done);
    tests++;
    if (n_win != NW || n_out != NW || n_done != 1) begin
      fails++;
      $display("FAIL abort_restart: got win=%0d out=%0d done=%0d want %0d/%0d/1",
               n_win, n_out, n_done, NW, NW);
    end
  endtask

  task automatic test_start_abort();
    int n_wr, n_win, n_out, n_done;
    drive_frame(100, -1, 1'b1, 1'b0, n_wr, n_win, n_out, n_done);
    tests++;
    if (n_wr != NPIX || n_done != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_held: got wr=%0d done=%0d busy=%b want %0d/1/0",
               n_wr, n_done, busy, NPIX);
    end
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      fails++; $display("FAIL start_abort: got busy=%b ready=%b want 0/0", busy, pix_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      conv_valid = ~i[0];
      @(negedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL idle_conv_valid[%0d]: out_valid got %b want 0", i, out_valid);
      end
    end
    conv_valid = 1'b0;
  endtask

  task automatic test_reset_drain();
    int n_wr, n_win, n_out, n_done;
    drive_frame(100, -1, 1'b0, 1'b1, n_wr, n_win, n_out, n_done);
    tests++;
    if (n_done != 0 || n_out >= NW) begin
      fails++; $display("FAIL reset_drain_frame: got done=%0d out=%0d want 0/<676", n_done, n_out);
    end
    drive_frame(100, -1, 1'b0, 1'b0, n_wr, n_win, n_out, n_done);
    tests++;
    if (n_win != NW || n_out != NW || n_done != 1) begin
      fails++;
      $display("FAIL post_reset_frame: got win=%0d out=%0d done=%0d want %0d/%0d/1",
               n_win, n_out, n_done, NW, NW);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_abort();
    test_start_abort();
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
